// File: rtl/soc_rom_wb_pkg.sv
// Shared widths, FSM encoding and helpers for the boot ROM Wishbone front-end.
package soc_rom_wb_pkg;

  localparam int unsigned RW              = 16;
  localparam int unsigned WB_ADDR_W       = 24;
  localparam int unsigned ROM_WORD_W      = 32;
  localparam int unsigned WAIT_CNT_W      = 3;
  localparam int unsigned MAX_WAIT_STATES = (1 << WAIT_CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Request fields captured from the bus in IDLE.
  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
  } wb_req_t;

  // Odd halfword address picks the upper half of a ROM word.
  function automatic logic [RW-1:0] hw_sel(input logic [ROM_WORD_W-1:0] word,
                                           input logic                  odd);
    return odd ? word[ROM_WORD_W-1 -: RW] : word[RW-1:0];
  endfunction

endpackage

// File: rtl/soc_rom.sv
// Combinational boot ROM array; contents come from the IMAGE parameter.
module soc_rom
  import soc_rom_wb_pkg::*;
#(
  parameter int unsigned                           WIN_W = 8,
  parameter logic [ROM_WORD_W*(2**(WIN_W-1))-1:0]  IMAGE = '0
) (
  input  logic [WB_ADDR_W-1:0] in_addr,
  output logic [RW-1:0]        out_data
);

  localparam int unsigned N_WORDS = 2**(WIN_W-1);
  localparam int unsigned IDX_W   = WIN_W - 1;

  logic [ROM_WORD_W-1:0] mem [N_WORDS];
  logic [IDX_W-1:0]      word_idx;
  logic                  unused_hi;

  // Unpack the flat image into 32-bit words.
  for (genvar g = 0; g < N_WORDS; g++) begin : g_word
    assign mem[g] = IMAGE[g*ROM_WORD_W +: ROM_WORD_W];
  end

  assign word_idx  = in_addr[WIN_W-1:1];
  assign out_data  = hw_sel(mem[word_idx], in_addr[0]);
  assign unused_hi = ^in_addr[WB_ADDR_W-1:WIN_W];

endmodule

// File: rtl/soc_rom_wb.sv
// Wishbone classic slave front-end for the boot ROM: window decode,
// programmable wait states, registered read data, single-cycle ack/err.
module soc_rom_wb
  import soc_rom_wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0]                  BASE_ADDR   = WB_ADDR_W'(24'hffe000),
  parameter int unsigned                           WIN_W       = 8,
  parameter int unsigned                           WAIT_STATES = 1,
  parameter logic [ROM_WORD_W*(2**(WIN_W-1))-1:0]  ROM_IMAGE   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [WB_ADDR_W-1:0] wb_adr,
  output logic [RW-1:0]        wb_o_dat,
  output logic                 wb_ack,
  output logic                 wb_err
);

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

  // The wait counter is only 3 bits wide.
  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("soc_rom_wb: WAIT_STATES must be in 0..7");
  end

  state_e                state_q, state_d;
  logic [WB_ADDR_W-1:0]  adr_q, adr_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]         dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  wb_req_t               req_c;
  logic                  req_vld_c;
  logic                  win_hit_c;
  logic [WB_ADDR_W-1:0]  rom_addr;
  logic [RW-1:0]         rom_data;
  logic                  unused_adr_hi;

  assign req_c     = '{we: wb_we, adr: wb_adr};
  // A response still on the bus blocks re-capture of the same strobe.
  assign req_vld_c = wb_cyc & wb_stb & ~ack_q & ~err_q;
  assign win_hit_c = (req_c.adr[WB_ADDR_W-1:WIN_W] == BASE_ADDR[WB_ADDR_W-1:WIN_W]);

  // ROM always sees the captured offset inside the window.
  assign rom_addr      = {BASE_ADDR[WB_ADDR_W-1:WIN_W], adr_q[WIN_W-1:0]};
  assign unused_adr_hi = ^adr_q[WB_ADDR_W-1:WIN_W];

  soc_rom #(
    .WIN_W (WIN_W),
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .in_addr  (rom_addr),
    .out_data (rom_data)
  );

  // Next-state and response logic.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_vld_c) begin
          adr_d = req_c.adr;
          cnt_d = WS_LOAD;
          if (req_c.we || !win_hit_c) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
          if (cnt_q == WAIT_CNT_W'(1)) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        dat_d   = rom_data;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= BASE_ADDR;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb_o_dat = dat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;

endmodule

// File: tb/tb_soc_rom_wb.sv
// Bench for soc_rom_wb: three instances with 1, 0 and 5 wait states share the
// bus; only the instance whose cyc is high takes part in a transaction.
module tb_soc_rom_wb;

  function automatic logic [31:0] img_word(input int i);
    case (i)
      0:       return 32'h1234_5678;
      1:       return 32'hcafe_0001;
      127:     return 32'hdead_beef;
      default: return {16'h8000 | 16'(i), 16'h4000 | 16'(i * 5)};
    endcase
  endfunction

  function automatic logic [4095:0] build_img();
    logic [4095:0] v;
    for (int i = 0; i < 128; i++) v[i*32 +: 32] = img_word(i);
    return v;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 5);
  endfunction

  // Halfword the ROM should return for an in-window address.
  function automatic logic [15:0] exp_hw(input logic [23:0] a);
    logic [31:0] w;
    w = img_word(int'(a[7:1]));
    return a[0] ? w[31:16] : w[15:0];
  endfunction

  localparam logic [4095:0] IMG = build_img();

  logic        clk;
  logic        rst_n;
  logic [2:0]  cyc;
  logic        stb;
  logic        we;
  logic [23:0] adr;
  logic [15:0] dat [3];
  logic [2:0]  ack;
  logic [2:0]  err;

  int checks    = 0;
  int failures  = 0;
  int resp_cnt  [3] = '{0, 0, 0};
  int exp_resp  [3] = '{0, 0, 0};
  int excl_viol = 0;
  logic [15:0] last_dat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    soc_rom_wb #(
      .BASE_ADDR   (24'hffe000),
      .WIN_W       (8),
      .WAIT_STATES (ws_of(g)),
      .ROM_IMAGE   (IMG)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .wb_cyc   (cyc[g]),
      .wb_stb   (stb),
      .wb_we    (we),
      .wb_adr   (adr),
      .wb_o_dat (dat[g]),
      .wb_ack   (ack[g]),
      .wb_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every response pulse and any cycle with ack and err together.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] | err[i]) resp_cnt[i]++;
      if (ack[i] & err[i]) excl_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One complete transfer; lat counts edges from the capture edge to the response.
  task automatic apply(input int d, input logic w, input logic [23:0] a,
                       input bit e_err, input logic [15:0] e_dat, input int e_lat,
                       input string nm);
    int lat;
    bit got_ack;
    bit got_err;
    cyc = '0; cyc[d] = 1'b1; stb = 1'b1; we = w; adr = a;
    lat = -1; got_ack = 1'b0; got_err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ack[d] | err[d]) begin
        lat = k - 1; got_ack = ack[d]; got_err = err[d];
        break;
      end
    end
    chk({nm, ".lat"}, 32'(lat), 32'(e_lat));
    chk({nm, ".err"}, 32'(got_err), 32'(e_err));
    chk({nm, ".ack"}, 32'(got_ack), 32'(!e_err));
    chk({nm, ".dat"}, 32'(dat[d]), 32'(e_dat));
    exp_resp[d]++;
    last_dat[d] = e_dat;
    cyc = '0; stb = 1'b0; we = 1'b0;
    tick();
    chk({nm, ".pulse"}, 32'({ack[d], err[d]}), 32'(0));
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [23:0] a;
    bit          e_err;
    logic [15:0] e_dat;
    int          e_lat;
  } vec_t;

  initial begin
    vec_t tbl [13];
    int   t1, t2, seen;
    logic [15:0] d1, d2;

    tbl[0]  = '{0, 1'b0, 24'hffe000, 1'b0, 16'h5678, 2};
    tbl[1]  = '{0, 1'b0, 24'hffe001, 1'b0, 16'h1234, 2};
    tbl[2]  = '{0, 1'b0, 24'hffe0ff, 1'b0, 16'hdead, 2};
    tbl[3]  = '{0, 1'b0, 24'hffe100, 1'b1, 16'hdead, 1};
    tbl[4]  = '{0, 1'b1, 24'hffe002, 1'b1, 16'hdead, 1};
    tbl[5]  = '{1, 1'b0, 24'hffe002, 1'b0, 16'h0001, 1};
    tbl[6]  = '{1, 1'b0, 24'hffe003, 1'b0, 16'hcafe, 1};
    tbl[7]  = '{1, 1'b0, 24'hffe1ff, 1'b1, 16'hcafe, 1};
    tbl[8]  = '{1, 1'b1, 24'hffe000, 1'b1, 16'hcafe, 1};
    tbl[9]  = '{1, 1'b0, 24'hffe0fe, 1'b0, 16'hbeef, 1};
    tbl[10] = '{2, 1'b0, 24'hffe000, 1'b0, 16'h5678, 6};
    tbl[11] = '{2, 1'b0, 24'hffdfff, 1'b1, 16'h5678, 1};
    tbl[12] = '{2, 1'b0, 24'hffe0fe, 1'b0, 16'hbeef, 6};

    rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0;
    for (int i = 0; i < 3; i++) last_dat[i] = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.ack%0d", i), 32'(ack[i]), 32'(0));
      chk($sformatf("reset.err%0d", i), 32'(err[i]), 32'(0));
      chk($sformatf("reset.dat%0d", i), 32'(dat[i]), 32'(0));
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++)
      apply(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].e_err, tbl[i].e_dat, tbl[i].e_lat,
            $sformatf("vec%0d", i));

    // Zero wait states with the strobe held: the ack still on the bus at the
    // closing edge blocks capture, so the stepped address is taken one edge later.
    cyc = '0; cyc[1] = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'hffe002;
    t1 = -1; t2 = -1; d1 = '0; d2 = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack[1]) begin
        if (t1 < 0) begin
          t1 = k; d1 = dat[1]; adr = 24'hffe003;
        end else begin
          t2 = k; d2 = dat[1];
          break;
        end
      end
    end
    cyc = '0; stb = 1'b0;
    tick();
    chk("b2b.first_lat", 32'(t1), 32'(2));
    chk("b2b.first_dat", 32'(d1), 32'(16'h0001));
    chk("b2b.gap", 32'(t2 - t1), 32'(3));
    chk("b2b.second_dat", 32'(d2), 32'(16'hcafe));
    exp_resp[1] += 2;
    last_dat[1] = 16'hcafe;

    // Strobe drops after capture; later address/we changes are ignored.
    cyc = '0; cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'hffe0ff;
    tick();
    stb = 1'b0; we = 1'b1; adr = 24'hffe000;
    t1 = -1; seen = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (ack[2] | err[2]) begin
        t1 = k - 1; seen = int'(err[2]);
        break;
      end
    end
    chk("stbdrop.lat", 32'(t1), 32'(6));
    chk("stbdrop.err", 32'(seen), 32'(0));
    chk("stbdrop.dat", 32'(dat[2]), 32'(16'hdead));
    exp_resp[2]++;
    last_dat[2] = 16'hdead;
    cyc = '0; we = 1'b0;
    tick();

    // Abort: cyc drops two cycles into the wait sequence.
    cyc[2] = 1'b1; stb = 1'b1; adr = 24'hffe001;
    tick();
    tick();
    cyc = '0; stb = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack[2] | err[2]) seen++;
    end
    chk("abort.no_resp", 32'(seen), 32'(0));
    chk("abort.dat", 32'(dat[2]), 32'(last_dat[2]));
    apply(2, 1'b0, 24'hffe001, 1'b0, 16'h1234, 6, "after_abort");

    // Reset in the middle of a wait sequence.
    cyc[2] = 1'b1; stb = 1'b1; adr = 24'hffe000;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst.ack%0d", i), 32'(ack[i]), 32'(0));
      chk($sformatf("midrst.err%0d", i), 32'(err[i]), 32'(0));
      chk($sformatf("midrst.dat%0d", i), 32'(dat[i]), 32'(0));
      last_dat[i] = '0;
    end
    rst_n = 1'b1; cyc = '0; stb = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack[2] | err[2]) seen++;
    end
    chk("midrst.no_resp", 32'(seen), 32'(0));
    apply(2, 1'b0, 24'hffe0ff, 1'b0, 16'hdead, 6, "after_rst");

    // Random transfers against the address-map model.
    for (int n = 0; n < 60; n++) begin
      int          d;
      logic        w;
      logic [23:0] a;
      bit          e_err;
      logic [15:0] e_dat;
      d = int'($urandom_range(0, 2));
      w = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 3) != 0) ? {16'hffe0, 8'($urandom)} : 24'($urandom);
      e_err = w || (a[23:8] != 16'hffe0);
      e_dat = e_err ? last_dat[d] : exp_hw(a);
      apply(d, w, a, e_err, e_dat, e_err ? 1 : 1 + ws_of(d), $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    chk("ack_err_exclusive", 32'(excl_viol), 32'(0));
    for (int i = 0; i < 3; i++)
      chk($sformatf("resp_count%0d", i), 32'(resp_cnt[i]), 32'(exp_resp[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
